// File: rtl/histogram_stats.sv
// Two-pass statistics scanner over a 256-bin histogram memory with a registered read port.
// Pass 1 gathers total, min/max occupied bin and mode; pass 2 finds the median bin.
module histogram_stats #(
  parameter int unsigned BIN_W = 8,
  parameter int unsigned ADR_W = 8,
  parameter int unsigned TOT_W = BIN_W + ADR_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  output logic             rd_en,
  output logic [ADR_W-1:0] rd_adr,
  input  logic [BIN_W-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic             empty,
  output logic [TOT_W-1:0] total,
  output logic [ADR_W-1:0] min_bin,
  output logic [ADR_W-1:0] max_bin,
  output logic [ADR_W-1:0] mode_bin,
  output logic [BIN_W-1:0] mode_cnt,
  output logic [ADR_W-1:0] median_bin
);

  localparam logic [ADR_W-1:0] LastAdr = {ADR_W{1'b1}};

  typedef enum logic [2:0] {
    StIdle,
    StP1,
    StP1End,
    StP2,
    StP2End,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic             start_q, start_d;
  logic [ADR_W-1:0] rd_adr_q, rd_adr_d;
  logic             rd_vld_q, rd_vld_d;
  logic [ADR_W-1:0] bin_q, bin_d;

  // Working accumulators
  logic [TOT_W-1:0] acc_tot_q, acc_tot_d;
  logic             acc_seen_q, acc_seen_d;
  logic [ADR_W-1:0] acc_min_q, acc_min_d;
  logic [ADR_W-1:0] acc_max_q, acc_max_d;
  logic [ADR_W-1:0] acc_mode_bin_q, acc_mode_bin_d;
  logic [BIN_W-1:0] acc_mode_cnt_q, acc_mode_cnt_d;
  logic [TOT_W-1:0] acc_cum_q, acc_cum_d;
  logic             acc_med_found_q, acc_med_found_d;
  logic [ADR_W-1:0] acc_med_q, acc_med_d;

  // Published results
  logic             empty_q, empty_d;
  logic [TOT_W-1:0] total_q, total_d;
  logic [ADR_W-1:0] min_bin_q, min_bin_d;
  logic [ADR_W-1:0] max_bin_q, max_bin_d;
  logic [ADR_W-1:0] mode_bin_q, mode_bin_d;
  logic [BIN_W-1:0] mode_cnt_q, mode_cnt_d;
  logic [ADR_W-1:0] median_bin_q, median_bin_d;

  logic [TOT_W-1:0] target;
  logic             pass2;

  assign target = (acc_tot_q + TOT_W'(1)) >> 1;
  assign pass2  = (state_q == StP2) || (state_q == StP2End);

  always_comb begin
    state_d         = state_q;
    start_d         = 1'b0;
    rd_adr_d        = rd_adr_q;
    rd_vld_d        = 1'b0;
    bin_d           = rd_adr_q;
    acc_tot_d       = acc_tot_q;
    acc_seen_d      = acc_seen_q;
    acc_min_d       = acc_min_q;
    acc_max_d       = acc_max_q;
    acc_mode_bin_d  = acc_mode_bin_q;
    acc_mode_cnt_d  = acc_mode_cnt_q;
    acc_cum_d       = acc_cum_q;
    acc_med_found_d = acc_med_found_q;
    acc_med_d       = acc_med_q;
    empty_d         = empty_q;
    total_d         = total_q;
    min_bin_d       = min_bin_q;
    max_bin_d       = max_bin_q;
    mode_bin_d      = mode_bin_q;
    mode_cnt_d      = mode_cnt_q;
    median_bin_d    = median_bin_q;
    rd_en           = 1'b0;
    busy            = 1'b0;
    done            = 1'b0;

    // rd_data belongs to bin_q whenever the previous cycle issued a read
    if (rd_vld_q) begin
      if (!pass2) begin
        acc_tot_d = acc_tot_q + TOT_W'(rd_data);
        if (rd_data != '0) begin
          if (!acc_seen_q) acc_min_d = bin_q;
          acc_seen_d = 1'b1;
          acc_max_d  = bin_q;
        end
        if (rd_data > acc_mode_cnt_q) begin
          acc_mode_cnt_d = rd_data;
          acc_mode_bin_d = bin_q;
        end
      end else begin
        acc_cum_d = acc_cum_q + TOT_W'(rd_data);
        if (!acc_med_found_q && (acc_cum_d >= target)) begin
          acc_med_found_d = 1'b1;
          acc_med_d       = bin_q;
        end
      end
    end

    unique case (state_q)
      StIdle: begin
        start_d = start;
        if (start_q) begin
          state_d         = StP1;
          rd_adr_d        = '0;
          acc_tot_d       = '0;
          acc_seen_d      = 1'b0;
          acc_min_d       = '0;
          acc_max_d       = '0;
          acc_mode_bin_d  = '0;
          acc_mode_cnt_d  = '0;
          acc_cum_d       = '0;
          acc_med_found_d = 1'b0;
          acc_med_d       = '0;
        end
      end
      StP1, StP2: begin
        rd_en    = 1'b1;
        busy     = 1'b1;
        rd_vld_d = 1'b1;
        if (rd_adr_q == LastAdr) begin
          state_d = (state_q == StP1) ? StP1End : StP2End;
        end else begin
          rd_adr_d = rd_adr_q + 1'b1;
        end
      end
      StP1End: begin
        busy     = 1'b1;
        state_d  = StP2;
        rd_adr_d = '0;
      end
      StP2End: begin
        busy    = 1'b1;
        state_d = StDone;
        // Publish from next-state values so the final median is included in DONE
        empty_d      = (acc_tot_d == '0);
        total_d      = acc_tot_d;
        min_bin_d    = acc_min_d;
        max_bin_d    = acc_max_d;
        mode_bin_d   = acc_mode_bin_d;
        mode_cnt_d   = acc_mode_cnt_d;
        median_bin_d = acc_med_d;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q         <= StIdle;
      start_q         <= 1'b0;
      rd_adr_q        <= '0;
      rd_vld_q        <= 1'b0;
      bin_q           <= '0;
      acc_tot_q       <= '0;
      acc_seen_q      <= 1'b0;
      acc_min_q       <= '0;
      acc_max_q       <= '0;
      acc_mode_bin_q  <= '0;
      acc_mode_cnt_q  <= '0;
      acc_cum_q       <= '0;
      acc_med_found_q <= 1'b0;
      acc_med_q       <= '0;
      empty_q         <= 1'b0;
      total_q         <= '0;
      min_bin_q       <= '0;
      max_bin_q       <= '0;
      mode_bin_q      <= '0;
      mode_cnt_q      <= '0;
      median_bin_q    <= '0;
    end else begin
      state_q         <= state_d;
      start_q         <= start_d;
      rd_adr_q        <= rd_adr_d;
      rd_vld_q        <= rd_vld_d;
      bin_q           <= bin_d;
      acc_tot_q       <= acc_tot_d;
      acc_seen_q      <= acc_seen_d;
      acc_min_q       <= acc_min_d;
      acc_max_q       <= acc_max_d;
      acc_mode_bin_q  <= acc_mode_bin_d;
      acc_mode_cnt_q  <= acc_mode_cnt_d;
      acc_cum_q       <= acc_cum_d;
      acc_med_found_q <= acc_med_found_d;
      acc_med_q       <= acc_med_d;
      empty_q         <= empty_d;
      total_q         <= total_d;
      min_bin_q       <= min_bin_d;
      max_bin_q       <= max_bin_d;
      mode_bin_q      <= mode_bin_d;
      mode_cnt_q      <= mode_cnt_d;
      median_bin_q    <= median_bin_d;
    end
  end

  assign rd_adr     = rd_adr_q;
  assign empty      = empty_q;
  assign total      = total_q;
  assign min_bin    = min_bin_q;
  assign max_bin    = max_bin_q;
  assign mode_bin   = mode_bin_q;
  assign mode_cnt   = mode_cnt_q;
  assign median_bin = median_bin_q;

endmodule

// File: tb/tb_histogram_stats.sv
// Bench for histogram_stats: 256x8 registered-read memory model, directed histograms,
// expected results queued at stimulus time and checked by a monitor on each done pulse.
module tb_histogram_stats;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic        rd_en;
  logic [7:0]  rd_adr;
  logic [7:0]  rd_data;
  logic        busy, done, empty;
  logic [15:0] total;
  logic [7:0]  min_bin, max_bin, mode_bin, mode_cnt, median_bin;

  logic [7:0] mem [256];
  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        empty;
    logic [15:0] total;
    logic [7:0]  min_b;
    logic [7:0]  max_b;
    logic [7:0]  mode_b;
    logic [7:0]  mode_c;
    logic [7:0]  med;
  } exp_t;
  exp_t exp_q[$];

  histogram_stats dut (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start),
    .rd_en      (rd_en),
    .rd_adr     (rd_adr),
    .rd_data    (rd_data),
    .busy       (busy),
    .done       (done),
    .empty      (empty),
    .total      (total),
    .min_bin    (min_bin),
    .max_bin    (max_bin),
    .mode_bin   (mode_bin),
    .mode_cnt   (mode_cnt),
    .median_bin (median_bin)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) rd_data <= mem[rd_adr];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation
  always @(negedge CLK) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected no done");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("empty", int'(empty), int'(e.empty));
        chk("total", int'(total), int'(e.total));
        chk("min_bin", int'(min_bin), int'(e.min_b));
        chk("max_bin", int'(max_bin), int'(e.max_b));
        chk("mode_bin", int'(mode_bin), int'(e.mode_b));
        chk("mode_cnt", int'(mode_cnt), int'(e.mode_c));
        chk("median_bin", int'(median_bin), int'(e.med));
      end
    end
  end

  task automatic clear_mem(input logic [7:0] v);
    for (int i = 0; i < 256; i++) mem[i] = v;
  endtask

  task automatic push_exp(input logic em, input int tot, input int mn, input int mx,
                          input int mb, input int mc, input int md);
    exp_t e;
    e.empty  = em;
    e.total  = 16'(tot);
    e.min_b  = 8'(mn);
    e.max_b  = 8'(mx);
    e.mode_b = 8'(mb);
    e.mode_c = 8'(mc);
    e.med    = 8'(md);
    exp_q.push_back(e);
  endtask

  // Pulse start, wait for done; optionally re-pulse start while busy at cycle extra_at
  task automatic run_scan(input string name, input int extra_at);
    int n, busy_cnt, rden_cnt, busy_falls;
    logic busy_prev;
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); start = 1'b0;
    n = 0; busy_cnt = 0; rden_cnt = 0; busy_falls = 0; busy_prev = 1'b0;
    while (!done && n < 600) begin
      if (busy) busy_cnt++;
      if (rd_en) rden_cnt++;
      if (busy_prev && !busy) busy_falls++;
      busy_prev = busy;
      @(negedge CLK);
      n++;
      start = (n == extra_at);
    end
    start = 1'b0;
    if (n >= 600) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got no done expected done within 600 cycles", name);
    end else begin
      chk({name, "_latency"}, n, 515);
      chk({name, "_busy_cycles"}, busy_cnt, 514);
      chk({name, "_rden_cycles"}, rden_cnt, 512);
      chk({name, "_busy_in_done"}, int'(busy), 0);
      if (extra_at > 0) chk({name, "_busy_falls"}, busy_falls + int'(busy_prev && !busy), 1);
    end
  endtask

  initial begin
    int n;
    clear_mem(8'd0);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rd_adr", int'(rd_adr), 0);
    chk("rst_total", int'(total), 0);
    chk("rst_empty", int'(empty), 0);
    chk("rst_median", int'(median_bin), 0);

    // Empty histogram
    push_exp(1'b1, 0, 0, 0, 0, 0, 0);
    run_scan("all_zero", 0);

    // Single bin
    clear_mem(8'd0); mem[37] = 8'd5;
    push_exp(1'b0, 5, 37, 37, 37, 5, 37);
    run_scan("single", 0);

    // Mode tie resolves low; median target 4
    clear_mem(8'd0); mem[10] = 8'd3; mem[200] = 8'd3; mem[255] = 8'd1;
    push_exp(1'b0, 7, 10, 255, 10, 3, 200);
    run_scan("tie", 0);

    // Full-scale bins
    clear_mem(8'd255);
    push_exp(1'b0, 65280, 0, 255, 0, 255, 127);
    run_scan("full", 0);

    // Reset mid-pass-1 aborts with no done
    clear_mem(8'd0); mem[5] = 8'd1;
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); start = 1'b0;
    n = 0;
    while (n < 100) begin
      if (rd_en) n++;
      @(negedge CLK);
    end
    RST = 1'b1;
    @(negedge CLK); RST = 1'b0;
    chk("abort_rd_en", int'(rd_en), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_total", int'(total), 0);
    repeat (600) @(negedge CLK);
    chk("abort_idle_busy", int'(busy), 0);
    push_exp(1'b0, 1, 5, 5, 5, 1, 5);
    run_scan("after_abort", 0);

    // Start while busy and while in DONE is ignored
    clear_mem(8'd0); mem[3] = 8'd2; mem[4] = 8'd2;
    push_exp(1'b0, 4, 3, 4, 3, 2, 3);
    run_scan("ignore", 200);
    start = 1'b1;
    @(negedge CLK); start = 1'b0;
    n = 0;
    repeat (600) begin
      if (busy) n++;
      @(negedge CLK);
    end
    chk("ignore_no_restart", n, 0);
    chk("ignore_held_median", int'(median_bin), 3);

    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/histogram_stats.md
Name: histogram_stats

Overview:
- Downstream consumer of the 256-bin pixel histogram memory.
- After a histogram frame is built, scans every bin through the memory's registered read port, in two passes:
  - pass 1: total, min/max occupied bin, mode;
  - pass 2: median.
- Results are registered and presented with a one-cycle done pulse for the control/threshold logic.

Parameters:
- BIN_W, 8, width of one bin count as returned by the histogram memory.
- ADR_W, 8, bin address width; number of bins N = 2**ADR_W.
- TOT_W, BIN_W+ADR_W, width of the total-count accumulator (never overflows).

Ports:
- CLK  in  1  single clock, all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to scan; sampled only in IDLE.
- rd_en  out  1  high while this block drives rd_adr (histogram read ownership).
- rd_adr  out  ADR_W  bin address presented to the histogram memory.
- rd_data  in  BIN_W  bin count; valid exactly 1 cycle after the corresponding rd_adr (registered read).
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; results valid from this cycle.
- empty  out  1  total count was zero.
- total  out  TOT_W  sum of all bins.
- min_bin  out  ADR_W  lowest bin with nonzero count.
- max_bin  out  ADR_W  highest bin with nonzero count.
- mode_bin  out  ADR_W  bin with the largest count.
- mode_cnt  out  BIN_W  count of mode_bin.
- median_bin  out  ADR_W  median bin.

Behaviour:
- Reset (synchronous, RST=1 at a rising edge):
  - state goes to IDLE.
  - All outputs and internal accumulators go to 0: rd_en, rd_adr, busy, done, empty, total, min_bin, max_bin, mode_bin, mode_cnt, median_bin.
  - RST mid-scan aborts the scan immediately; no done pulse is produced for the aborted scan.
- States: IDLE -> P1 -> P1_END -> P2 -> P2_END -> DONE -> IDLE.
- IDLE:
  - rd_en=0, busy=0.
  - start=1 moves to P1 and clears the working accumulators.
  - Published results are untouched.
- P1 (N cycles):
  - rd_en=1; rd_adr counts 0..N-1, one address per cycle.
  - Each cycle consumes the rd_data for the previous cycle's address.
- P1_END (1 cycle): rd_en=0; consumes the data for address N-1.
- Pass-1 rules, per consumed bin b with count c:
  - total += c, at width TOT_W.
  - If c!=0 and no nonzero bin has been seen yet: min_bin_w = b.
  - If c!=0: max_bin_w = b.
  - If c > mode_cnt_w (strictly greater): mode_cnt_w = c and mode_bin_w = b. Ties resolve to the lowest bin.
- P2 / P2_END: same address/data timing as P1/P1_END.
  - A running cumulative sum is kept.
  - target = (total+1)>>1.
  - median_bin_w = first b where the cumulative sum including b is >= target, latched once.
  - The scan always runs all N bins; there is no early exit, so latency is fixed.
- DONE (1 cycle):
  - done=1, busy=0.
  - All result outputs update from the working registers in this same cycle.
  - Results hold until the next DONE or RST.
- Empty histogram (total=0): empty=1 and min_bin=max_bin=mode_bin=mode_cnt=median_bin=0.
- Latency: with start sampled at edge t, done is high in the cycle following edge t+2N+3 (N=256 gives 515 edges).
  - busy is high for 2N+2 cycles; rd_en is high for 2N cycles.
- start while busy or in DONE: ignored, not queued.
- rd_adr wrap: the counter reaches N-1 and is reloaded to 0 for P2. Address N-1 must be read; no off-by-one at the wrap.
- rd_adr holds its last value whenever rd_en=0.
- Counts are unsigned. Bin values up to 2**BIN_W-1 must accumulate without loss: max total is N*(2**BIN_W-1) < 2**TOT_W.

Test Plan:
Bench uses a 256x8 memory model with 1-cycle registered read.
- All bins 0, pulse start -> done exactly 515 cycles later; empty=1, total=0, all bin outputs 0.
- Only bin 37=5 -> total=5, min=max=mode=median=37, mode_cnt=5, empty=0.
- Bins 10=3, 200=3, 255=1 -> total=7, min=10, max=255, mode_bin=10 (tie, lowest), mode_cnt=3, median=200 (target 4).
- All bins 255 -> total=65280, min=0, max=255, mode_bin=0, mode_cnt=255, median=127 (cumulative 32640 >= target 32640).
- Start, assert RST at cycle 100 of P1, release, start again with bin 5=1 -> no done during the first scan; rd_en=0 the cycle after RST; second scan gives total=1 and median=5.
- Second start pulse asserted while busy -> ignored: exactly one done pulse, and busy falls only once.
